ucie_ahb_mst: RTL
=================

UCIE_AHB_MST -- requirements
Module: ucie_ahb_mst

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, AHB address width.
REQ-002 SHALL have parameter DWIDTH, default 32, AHB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, wait-state limit before abort.
REQ-004 SHALL have ports:
- i_hclk  in  1  sole clock.
- i_hreset  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  AWIDTH  byte address.
- i_cmd_wdata  in  DWIDTH  write data.
- i_cmd_size  in  3  AHB HSIZE encoding.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed.
- o_rsp_rdata  out  DWIDTH  read data; 0 for writes.
- o_rsp_status  out  2  00 OK, 01 slave ERROR, 10 misaligned/oversize, 11 timeout.
- o_busy  out  1  transfer in flight.
- o_haddr  out  AWIDTH; o_hwrite out 1; o_hsel out 1; o_htrans out 2; o_hsize out 3; o_hburst out 3; o_hwdata out DWIDTH  AHB-Lite master outputs.
- i_hready  in  1; i_hrdata in DWIDTH; i_hresp in 2  AHB-Lite master inputs.

Function
REQ-005 SHALL implement states IDLE, ADDR, DATA, RESP.
REQ-006 SHALL drive o_cmd_ready = 1 only in IDLE.
REQ-007 SHALL, on accept in cycle N with a legal command, register the command and drive the address phase in cycle N+1: o_htrans = NONSEQ, o_hsel = 1, o_hburst = SINGLE, o_haddr/o_hwrite/o_hsize from the command.
REQ-008 SHALL hold all address-phase outputs stable while i_hready = 0 in ADDR.
REQ-009 SHALL, on the first edge with i_hready = 1 in ADDR, enter DATA, drive o_htrans = IDLE and o_hsel = 0, and drive o_hwdata = command wdata for the full data phase.
REQ-010 SHALL, on the first edge with i_hready = 1 in DATA, capture i_hrdata (reads only) and i_hresp (OKAY -> 00, ERROR -> 01), then enter RESP.
REQ-011 SHALL tolerate the two-cycle ERROR response (hready = 0 then 1) without issuing a new transfer; status is captured on the hready = 1 cycle only.
REQ-012 SHALL assert o_rsp_valid throughout RESP, with rdata/status stable, and return to IDLE on i_rsp_ready = 1.
REQ-013 SHALL treat a command with i_cmd_size > log2(DWIDTH/8), or an i_cmd_addr not aligned to 2^size, as illegal: no AHB transfer; go directly IDLE -> RESP with status 10.
REQ-014 SHALL keep at most one transfer outstanding and never issue SEQ or BUSY.
REQ-015 SHALL drive o_busy = 1 in ADDR and DATA only.

Reset
REQ-016 SHALL, on i_hreset assertion at any time, asynchronously enter IDLE and drop any in-flight command and pending response.
REQ-017 SHALL reset outputs: o_htrans = IDLE, o_hsel = 0, o_hwrite = 0, o_haddr = 0, o_hwdata = 0, o_hsize = 0, o_hburst = 0, o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_status = 0, o_busy = 0; o_cmd_ready = 1 once reset is released.

Configuration
REQ-018 SHALL support the macro UCIE_AHB_MST_TIMEOUT_EN.
- Defined: a counter clears on entry to ADDR and counts cycles in ADDR/DATA with i_hready = 0. On reaching TIMEOUT_CYCLES: drive o_htrans = IDLE and o_hsel = 0, enter RESP with status 11 and rdata 0.
- Undefined: no counter; waits indefinitely; status 11 is never produced.

Structure
REQ-019 SHALL import package ucie_ahb_pkg holding the HTRANS, HRESP, HSIZE and HBURST constants, the status typedef, and the state enum.
REQ-020 SHALL place the timeout counter in sub-module ucie_ahb_mst_wdog, instantiated only under UCIE_AHB_MST_TIMEOUT_EN.

Verification
REQ-021 Write 0xDEADBEEF to 0x40, size 2, zero wait states -> NONSEQ in N+1, hwdata 0xDEADBEEF in N+2, rsp_valid in N+3 with status 00.
REQ-022 Read 0x44 with 3 wait states in the address phase, slave returns 0x12345678 -> haddr held 4 cycles; rdata 0x12345678, status 00.
REQ-023 Read 0x48 with two-cycle ERROR response -> no new NONSEQ; status 01.
REQ-024 Write to 0x42 with size 2 -> no NONSEQ on bus; rsp_valid next cycle with status 10.
REQ-025 With the macro defined and TIMEOUT_CYCLES = 8, hready held low -> abort after 8 cycles, htrans IDLE, status 11; without the macro, still busy after 1000 cycles.
REQ-026 Assert i_hreset mid-DATA with i_rsp_ready held 0 -> all outputs at reset values immediately; o_cmd_ready = 1 after release.

Source files
------------

// File: rtl/ucie_ahb_pkg.sv
// Shared AHB-Lite encodings, response status codes and master FSM states
// for the UCIe AHB master slice.
package ucie_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_SLV_ERR = 2'b01,
      RSP_ILLEGAL = 2'b10,
      RSP_TIMEOUT = 2'b11
   } rsp_status_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } mst_state_t;

endpackage

// File: rtl/ucie_ahb_mst_wdog.sv
// Wait-state watchdog for ucie_ahb_mst; only instantiated when
// UCIE_AHB_MST_TIMEOUT_EN is defined.
module ucie_ahb_mst_wdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic i_hclk,
   input  logic i_hreset,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset)
         count <= '0;
      else if (i_clear)
         count <= '0;
      else if (i_count)
         count <= count + 1'b1;
   end

   // Fires on the wait cycle that brings the total to TIMEOUT_CYCLES.
   assign o_expired = i_count && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ucie_ahb_mst.sv
// Single-outstanding AHB-Lite master turning command/response handshakes into
// NONSEQ SINGLE transfers. Define UCIE_AHB_MST_TIMEOUT_EN to enable the wait-state abort.
module ucie_ahb_mst
   import ucie_ahb_pkg::*;
#(
   parameter int AWIDTH         = 32,
   parameter int DWIDTH         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              i_hclk,
   input  logic              i_hreset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [AWIDTH-1:0] i_cmd_addr,
   input  logic [DWIDTH-1:0] i_cmd_wdata,
   input  logic [2:0]        i_cmd_size,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DWIDTH-1:0] o_rsp_rdata,
   output logic [1:0]        o_rsp_status,
   output logic              o_busy,
   output logic [AWIDTH-1:0] o_haddr,
   output logic              o_hwrite,
   output logic              o_hsel,
   output logic [1:0]        o_htrans,
   output logic [2:0]        o_hsize,
   output logic [2:0]        o_hburst,
   output logic [DWIDTH-1:0] o_hwdata,
   input  logic              i_hready,
   input  logic [DWIDTH-1:0] i_hrdata,
   input  logic [1:0]        i_hresp
);

   localparam int MAX_SIZE = $clog2(DWIDTH / 8);

   mst_state_t        state;
   mst_state_t        state_nxt;
   logic              cmd_write_q;
   logic [AWIDTH-1:0] cmd_addr_q;
   logic [DWIDTH-1:0] cmd_wdata_q;
   logic [2:0]        cmd_size_q;
   logic [DWIDTH-1:0] rsp_rdata_q;
   rsp_status_t       rsp_status_q;
   logic [AWIDTH-1:0] align_mask;
   logic              cmd_legal;
   logic              accept;
   logic              timeout_hit;

   // A command is legal when it fits the data bus and is naturally aligned.
   assign align_mask = (AWIDTH'(1) << i_cmd_size) - AWIDTH'(1);
   assign cmd_legal  = (int'(i_cmd_size) <= MAX_SIZE) && ((i_cmd_addr & align_mask) == '0);
   assign accept     = (state == S_IDLE) && i_cmd_valid;

`ifdef UCIE_AHB_MST_TIMEOUT_EN
   ucie_ahb_mst_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .i_hclk    (i_hclk),
      .i_hreset  (i_hreset),
      .i_clear   (accept && cmd_legal),
      .i_count   (((state == S_ADDR) || (state == S_DATA)) && !i_hready),
      .o_expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Only the address phase drives NONSEQ; everything else parks the bus at IDLE.
   always_comb begin
      state_nxt   = state;
      o_htrans    = HTRANS_IDLE;
      o_hsel      = 1'b0;
      o_busy      = 1'b0;
      o_rsp_valid = 1'b0;
      o_cmd_ready = 1'b0;
      case (state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid)
               state_nxt = cmd_legal ? S_ADDR : S_RESP;
         end
         S_ADDR: begin
            o_htrans = HTRANS_NONSEQ;
            o_hsel   = 1'b1;
            o_busy   = 1'b1;
            if (timeout_hit)
               state_nxt = S_RESP;
            else if (i_hready)
               state_nxt = S_DATA;
         end
         S_DATA: begin
            o_busy = 1'b1;
            if (timeout_hit || i_hready)
               state_nxt = S_RESP;
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Illegal commands never touch the bus registers, so the last legal
   // address stays parked on o_haddr.
   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset) begin
         cmd_write_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_size_q   <= '0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= RSP_OK;
      end else if (accept) begin
         if (cmd_legal) begin
            cmd_write_q <= i_cmd_write;
            cmd_addr_q  <= i_cmd_addr;
            cmd_wdata_q <= i_cmd_wdata;
            cmd_size_q  <= i_cmd_size;
         end else begin
            rsp_rdata_q  <= '0;
            rsp_status_q <= RSP_ILLEGAL;
         end
      end else if (timeout_hit) begin
         rsp_rdata_q  <= '0;
         rsp_status_q <= RSP_TIMEOUT;
      end else if ((state == S_DATA) && i_hready) begin
         rsp_rdata_q  <= cmd_write_q ? '0 : i_hrdata;
         rsp_status_q <= (i_hresp == HRESP_OKAY) ? RSP_OK : RSP_SLV_ERR;
      end
   end

   assign o_haddr      = cmd_addr_q;
   assign o_hwrite     = cmd_write_q;
   assign o_hsize      = cmd_size_q;
   assign o_hburst     = HBURST_SINGLE;
   assign o_hwdata     = (state == S_DATA) ? cmd_wdata_q : '0;
   assign o_rsp_rdata  = rsp_rdata_q;
   assign o_rsp_status = rsp_status_q;

endmodule
